// File: rtl/key_conditioner.sv
// Three-channel pushbutton conditioner: 2-flop sync, debounce FSM, one-cycle press pulse.
// Define AUTO_REPEAT_EN to add auto-repeat pulses while a key stays held.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned REPEAT_DLY   = 25000000,
  parameter int unsigned REPEAT_PER   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_hr,
  input  logic       key_min,
  input  logic       key_sec,
  output logic       ad_hr,
  output logic       ad_min,
  output logic       ad_sec,
  output logic [2:0] held
);

  // state  | meaning
  // IDLE   | key released and stable
  // DEB_DN | key seen low, counting stable-low cycles
  // HELD   | press accepted, pulse issued on entry
  // DEB_UP | key seen high, counting stable-high cycles
  typedef enum logic [1:0] {IDLE, DEB_DN, HELD, DEB_UP} state_e;

  localparam logic [25:0] DEB_LAST = 26'(DEBOUNCE_CYC - 1);

  // Parameters outside 2..2^26-1 are not supported; this block only marks them.
  if (DEBOUNCE_CYC < 2 || REPEAT_DLY < 2 || REPEAT_PER < 2) begin : g_illegal_params
  end

  logic [2:0] key_raw;
  logic [2:0] sync_a_q, sync_b_q;
  logic [2:0] pulse_vec;

  assign key_raw = {key_hr, key_min, key_sec};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a_q <= 3'b111;
      sync_b_q <= 3'b111;
    end else begin
      sync_a_q <= key_raw;
      sync_b_q <= sync_a_q;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    state_e      state_q, state_d;
    logic [25:0] cnt_q, cnt_d;
    logic [25:0] cnt_inc;
    logic        pulse_q, pulse_d;
    logic        key_s;

    assign key_s   = sync_b_q[i];
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 26'd1;

`ifdef AUTO_REPEAT_EN
    localparam logic [25:0] REP_LAST   = 26'(REPEAT_DLY - 1);
    localparam logic [25:0] REP_RELOAD = 26'(REPEAT_DLY - REPEAT_PER);
    logic [25:0] rep_q, rep_d;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) rep_q <= '0;
      else      rep_q <= rep_d;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_d   = rep_q;
`endif
      unique case (state_q)
        IDLE: begin
          if (!key_s) begin
            state_d = DEB_DN;
            cnt_d   = '0;
          end
        end
        DEB_DN: begin
          if (key_s) begin
            state_d = IDLE;
          end else if (cnt_q == DEB_LAST) begin
            state_d = HELD;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          if (key_s) begin
            state_d = DEB_UP;
            cnt_d   = '0;
          end
        end
        DEB_UP: begin
          // A low bounce returns to HELD without a new pulse; repeat timing carries on.
          if (!key_s) begin
            state_d = HELD;
          end else if (cnt_q == DEB_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
`ifdef AUTO_REPEAT_EN
      if (state_q == DEB_DN) begin
        rep_d = '0;
      end else if (state_q == HELD || state_q == DEB_UP) begin
        if (rep_q == REP_LAST) begin
          rep_d   = REP_RELOAD;
          pulse_d = 1'b1;
        end else if (rep_q != '1) begin
          rep_d = rep_q + 26'd1;
        end
      end
`endif
    end

    assign pulse_vec[i] = pulse_q;
    assign held[i]      = (state_q == HELD) || (state_q == DEB_UP);
  end

  assign ad_hr  = pulse_vec[2];
  assign ad_min = pulse_vec[1];
  assign ad_sec = pulse_vec[0];

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with short debounce/repeat parameters; expected pulses
// are queued by each scenario and matched by a negedge monitor.
module tb_key_conditioner;

  localparam int D   = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_hr = 1'b1, key_min = 1'b1, key_sec = 1'b1;
  logic ad_hr, ad_min, ad_sec;
  logic [2:0] held;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {int ch; int cyc;} ev_t;
  ev_t exp_q[$];

  key_conditioner #(.DEBOUNCE_CYC(D), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
    .clk(clk), .rst(rst),
    .key_hr(key_hr), .key_min(key_min), .key_sec(key_sec),
    .ad_hr(ad_hr), .ad_min(ad_min), .ad_sec(ad_sec),
    .held(held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every observed pulse must match the next queued expectation (channel and cycle).
  always @(negedge clk) begin
    logic [2:0] ad;
    ev_t e;
    ad = {ad_hr, ad_min, ad_sec};
    for (int c = 2; c >= 0; c--) begin
      if (ad[c]) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pulse_unexpected ch=%0d got_cyc=%0d want=no_pulse", c, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.ch !== c || e.cyc !== cyc) begin
            failures++;
            $display("FAIL pulse_match got ch=%0d cyc=%0d want ch=%0d cyc=%0d", c, cyc, e.ch, e.cyc);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int ch, input int at);
    ev_t e;
    e.ch = ch;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(3);
    checks++;
    if ({ad_hr, ad_min, ad_sec} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ad got=%b want=000", {ad_hr, ad_min, ad_sec});
    end
    checks++;
    if (held !== 3'b000) begin
      failures++;
      $display("FAIL reset_held got=%b want=000", held);
    end
    rst = 1'b1;
    step(3);
  endtask

  task automatic test_single_press();
    int k, r;
    k = cyc;
    key_min = 1'b0;
    push(1, k + D + 3);
    step(D + 2);
    checks++;
    if (held !== 3'b000) begin failures++; $display("FAIL press_held_early got=%b want=000", held); end
    step(1);
    checks++;
    if (held !== 3'b010) begin failures++; $display("FAIL press_held got=%b want=010", held); end
    step(1);
    checks++;
    if (held !== 3'b010 || ad_min !== 1'b0) begin
      failures++;
      $display("FAIL press_after got held=%b ad_min=%b want held=010 ad_min=0", held, ad_min);
    end
    step(4);
    r = cyc;
    key_min = 1'b1;
    step(D + 2);
    checks++;
    if (held !== 3'b010) begin failures++; $display("FAIL release_held_early got=%b want=010", held); end
    step(1);
    checks++;
    if (held !== 3'b000) begin failures++; $display("FAIL release_held got=%b want=000 r=%0d", held, r); end
    step(3);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL press_missing got=%0d pending want=0", exp_q.size()); end
  endtask

  task automatic test_glitch();
    logic [2:0] seen;
    seen = 3'b000;
    key_hr = 1'b0;
    step(3);
    key_hr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      seen |= held;
    end
    checks++;
    if (seen !== 3'b000) begin failures++; $display("FAIL glitch_held got=%b want=000", seen); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL glitch_queue got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_release_bounce();
    int k;
    k = cyc;
    key_sec = 1'b0;
    push(0, k + D + 3);
    step(10);
    checks++;
    if (held !== 3'b001) begin failures++; $display("FAIL bounce_press_held got=%b want=001", held); end
    key_sec = 1'b1; step(1);
    key_sec = 1'b0; step(1);
    key_sec = 1'b1; step(1);
    key_sec = 1'b0; step(1);
    key_sec = 1'b1;
    step(D + 2);
    checks++;
    if (held !== 3'b001) begin failures++; $display("FAIL bounce_held_early got=%b want=001", held); end
    step(1);
    checks++;
    if (held !== 3'b000) begin failures++; $display("FAIL bounce_release got=%b want=000", held); end
    step(5);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL bounce_queue got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_simultaneous();
    int k;
    k = cyc;
    key_hr = 1'b0;
    key_sec = 1'b0;
    push(2, k + D + 3);
    push(0, k + D + 3);
    step(D + 3);
    checks++;
    if (held !== 3'b101) begin failures++; $display("FAIL simul_held got=%b want=101", held); end
    key_hr = 1'b1;
    key_sec = 1'b1;
    step(10);
    checks++;
    if (held !== 3'b000) begin failures++; $display("FAIL simul_release got=%b want=000", held); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL simul_queue got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int k2;
    key_min = 1'b0;
    step(4);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (held !== 3'b000 || {ad_hr, ad_min, ad_sec} !== 3'b000) begin
      failures++;
      $display("FAIL rst_deb got held=%b ad=%b want 000/000", held, {ad_hr, ad_min, ad_sec});
    end
    step(2);
    k2 = cyc;
    push(1, k2 + D + 3);
    rst = 1'b1;
    step(D + 2);
    checks++;
    if (held !== 3'b000) begin failures++; $display("FAIL rst_fresh_early got=%b want=000", held); end
    step(1);
    checks++;
    if (held !== 3'b010) begin failures++; $display("FAIL rst_fresh_held got=%b want=010", held); end
    step(2);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (held !== 3'b000) begin failures++; $display("FAIL rst_hold_abort got=%b want=000", held); end
    key_min = 1'b1;
    step(2);
    rst = 1'b1;
    step(10);
    checks++;
    if (held !== 3'b000) begin failures++; $display("FAIL rst_after got=%b want=000", held); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rst_queue got=%0d want=0", exp_q.size()); end
  endtask

`ifdef AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    int k, p, r;
    k = cyc;
    p = k + D + 3;
    r = p + 30;
    key_hr = 1'b0;
    push(2, p);
    // Repeats continue through the release debounce until the channel is back in IDLE.
    for (int s = p + DLY; s <= r + D + 3; s += PER) push(2, s);
    step(r - cyc);
    key_hr = 1'b1;
    step(15);
    checks++;
    if (held !== 3'b000) begin failures++; $display("FAIL repeat_release got=%b want=000", held); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL repeat_queue got=%0d want=0", exp_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid();
`ifdef AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYC, default 1000000, meaning the stable-level cycles needed to accept a press or release (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter REPEAT_DLY, default 25000000, meaning the cycles from accepted press to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PER, default 10000000, meaning the cycles between subsequent auto-repeat pulses.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port key_hr, input, 1 bit: raw hour-adjust pushbutton, asynchronous, active-low (0 = pressed).
REQ-007 The block SHALL have port key_min, input, 1 bit: raw minute-adjust pushbutton, active-low.
REQ-008 The block SHALL have port key_sec, input, 1 bit: raw second-adjust pushbutton, active-low.
REQ-009 The block SHALL have port ad_hr, output, 1 bit: one-cycle, active-high hour-increment pulse to the clock counter stage.
REQ-010 The block SHALL have port ad_min, output, 1 bit: one-cycle, active-high minute-increment pulse.
REQ-011 The block SHALL have port ad_sec, output, 1 bit: one-cycle, active-high second-increment pulse.
REQ-012 The block SHALL have port held, output, 3 bits, {hr,min,sec}: debounced pressed level per key.

Function
REQ-013 Each key SHALL pass through a 2-flop synchronizer before any other logic uses it; the synchronizer resets to 1 (released).
REQ-014 The three channels SHALL be identical and fully independent, each with its own FSM and 26-bit counters.
REQ-015 The FSM states SHALL be IDLE, DEB_DN, HELD and DEB_UP.
REQ-016 IDLE: synced key = 0 -> DEB_DN with cnt cleared.
REQ-017 DEB_DN: synced key = 1 -> IDLE; otherwise cnt++; cnt = DEBOUNCE_CYC-1 -> HELD with rep cleared.
REQ-018 Entry into HELD from DEB_DN SHALL assert the channel's ad_* output (registered) for exactly one cycle.
REQ-019 Latency: with the pin held low from clock edge N, ad_* SHALL be high in the cycle after edge N+DEBOUNCE_CYC+2.
REQ-020 HELD: synced key = 1 -> DEB_UP with cnt cleared.
REQ-021 DEB_UP: synced key = 0 -> HELD, with rep continuing (not cleared) and no pulse; cnt = DEBOUNCE_CYC-1 -> IDLE; release SHALL never produce a pulse.
REQ-022 held[i] SHALL be 1 while channel i is in HELD or DEB_UP, and 0 otherwise.
REQ-023 Any low glitch shorter than DEBOUNCE_CYC synced cycles SHALL produce no pulse and no held assertion.
REQ-024 Simultaneous accepted presses on several keys SHALL each pulse in the same cycle; there is no arbitration.
REQ-025 Counters SHALL saturate and never wrap; parameters are legal for values 2 to 2^26-1.

Reset
REQ-026 While rst = 0, all FSMs SHALL be IDLE, all counters 0, synchronizers 1, and ad_hr/ad_min/ad_sec/held 0, asynchronously.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abort that activity with no pulse.
REQ-028 After rst deasserts, a key still held low SHALL be treated as a fresh press (full debounce, then one pulse).

Configuration
REQ-029 With macro AUTO_REPEAT_EN defined, HELD SHALL increment rep each cycle, pulse at rep = REPEAT_DLY-1, then pulse every REPEAT_PER cycles while in HELD/DEB_UP.
REQ-030 With AUTO_REPEAT_EN defined, rep SHALL reload to REPEAT_DLY-REPEAT_PER after each repeat pulse.
REQ-031 Without AUTO_REPEAT_EN, rep logic SHALL be absent and exactly one pulse is produced per accepted press.

Verification (DEBOUNCE_CYC=4, REPEAT_DLY=10, REPEAT_PER=3)
REQ-032 key_min low from edge 0, held -> ad_min high for one cycle after edge 6; held[1] = 1 from that point; no other output toggles.
REQ-033 key_hr low for 3 cycles, then high -> ad_hr never asserts; held stays 0.
REQ-034 key_sec bounces 1-0-1-0 during release, then stays high 4+ cycles -> no extra ad_sec pulse; held[0] falls after the stable release.
REQ-035 AUTO_REPEAT_EN defined, key_hr held 30 cycles -> ad_hr pulses at press+0, +10, +13, +16, +19, ...; none after release.
REQ-036 key_hr and key_sec pressed on the same edge -> ad_hr and ad_sec pulse in the same cycle.
REQ-037 rst pulsed low during DEB_DN -> outputs 0 immediately; a key still held after reset yields one pulse after a full debounce.
